opicorv32_pcpi_seqmul: RTL and testbench

Sequential RV32M multiply coprocessor on the responder side of the PCPI interface. Sits beside the core's PCPI initiator and answers MUL, MULH, MULHSU and MULHU with a registered, multi-cycle shift-add datapath. Its four response outputs feed the core's external PCPI response inputs, and its request inputs mirror the core's PCPI request outputs.

---
 rtl/opicorv32_pcpi_pkg.sv | 30 +++
 rtl/opicorv32_mul_step.sv | 26 ++
 rtl/opicorv32_pcpi_seqmul.sv | 121 ++++++++++++
 tb/tb_opicorv32_pcpi_seqmul.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/opicorv32_pcpi_pkg.sv
// Shared decode constants, enums and helpers for the PCPI multiply coprocessor.
package opicorv32_pcpi_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } seqmul_state_t;

  // insn[14] separates the multiplies from DIV/DIVU/REM/REMU.
  function automatic logic is_mul_insn(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && !insn[14];
  endfunction

  function automatic logic [31:0] select_result(input mul_op_t op, input logic [63:0] acc);
    return (op == OP_MUL) ? acc[31:0] : acc[63:32];
  endfunction

endpackage

// File: rtl/opicorv32_mul_step.sv
// Combinational shift-add slice: retires STEPS_AT_ONCE multiplier bits per use.
module opicorv32_mul_step #(
  parameter int STEPS_AT_ONCE = 1
) (
  input  logic [63:0] acc,
  input  logic [63:0] mcand,
  input  logic [63:0] mplier,
  output logic [63:0] acc_next,
  output logic [63:0] mcand_next,
  output logic [63:0] mplier_next
);

  always_comb begin
    // NOTE: blocking assignments here build an unrolled chain of adders; each
    // iteration sees the previous iteration's value, which is the intent.
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    for (int i = 0; i < STEPS_AT_ONCE; i++) begin
      if (mplier_next[0]) acc_next = acc_next + mcand_next;
      mcand_next  = {mcand_next[62:0], 1'b0};
      mplier_next = {1'b0, mplier_next[63:1]};
    end
  end

endmodule

// File: rtl/opicorv32_pcpi_seqmul.sv
// PCPI responder for MUL/MULH/MULHSU/MULHU using a multi-cycle shift-add datapath.
module opicorv32_pcpi_seqmul
  import opicorv32_pcpi_pkg::*;
#(
  parameter int STEPS_AT_ONCE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam logic [5:0] CNT_INIT = 6'(64 / STEPS_AT_ONCE - 1);

  seqmul_state_t state;
  mul_op_t       op;
  logic [63:0]   acc, mcand, mplier;
  logic [63:0]   acc_nxt, mcand_nxt, mplier_nxt;
  logic [5:0]    cnt;

  logic          insn_match;
  mul_op_t       insn_op;
  logic [63:0]   rs1_ext, rs2_ext;
  logic          unused_insn_fields;

  assign insn_match = is_mul_insn(pcpi_insn);
  assign insn_op    = mul_op_t'(pcpi_insn[13:12]);

  // Register specifiers are the core's business; only the opcode fields matter here.
  assign unused_insn_fields = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  assign rs1_ext = ((insn_op == OP_MULH) || (insn_op == OP_MULHSU)) ?
                   {{32{pcpi_rs1[31]}}, pcpi_rs1} : {32'b0, pcpi_rs1};
  assign rs2_ext = (insn_op == OP_MULH) ?
                   {{32{pcpi_rs2[31]}}, pcpi_rs2} : {32'b0, pcpi_rs2};

  opicorv32_mul_step #(
    .STEPS_AT_ONCE(STEPS_AT_ONCE)
  ) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_next   (acc_nxt),
    .mcand_next (mcand_nxt),
    .mplier_next(mplier_nxt)
  );

  assign pcpi_wr = pcpi_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the datapath registers are plain flops (not a memory), so they
      // are cleared with the control state for a deterministic post-reset view.
      state      <= S_IDLE;
      op         <= OP_MUL;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pcpi_valid && insn_match) begin
            op        <= insn_op;
            acc       <= '0;
            mcand     <= rs1_ext;
            mplier    <= rs2_ext;
            cnt       <= CNT_INIT;
            pcpi_wait <= 1'b1;
            state     <= S_CALC;
          end
        end

        S_CALC: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            state     <= S_IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            if (cnt == '0) begin
              pcpi_wait  <= 1'b0;
              pcpi_ready <= 1'b1;
              pcpi_rd    <= select_result(op, acc_nxt);
              state      <= S_RESP;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end

        S_RESP: begin
          pcpi_ready <= 1'b0;
          pcpi_rd    <= '0;
          state      <= pcpi_valid ? S_DRAIN : S_IDLE;
        end

        S_DRAIN: begin
          // The core still holds the finished request; wait for it to drop.
          if (!pcpi_valid) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opicorv32_pcpi_seqmul.sv
// Self-checking bench for opicorv32_pcpi_seqmul at STEPS_AT_ONCE=4 (17-cycle latency).
module tb_opicorv32_pcpi_seqmul;

  localparam int STEPS = 4;
  localparam int LAT   = 1 + 64 / STEPS;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  opicorv32_pcpi_seqmul #(.STEPS_AT_ONCE(STEPS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics as a full 64-bit product of extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'b01 || op == 2'b10) ? 64'($signed(a)) : 64'(a);
    y = (op == 2'b01) ? 64'($signed(b)) : 64'(b);
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk_insn(input logic [1:0] op);
    return {7'b0000001, 5'd3, 5'd2, 1'b0, op, 5'd1, 7'b0110011};
  endfunction

  // Issue one request, check latency/busy profile/result, hold valid `hold`
  // cycles past ready, then release and confirm no second pulse.
  task automatic run_mul(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] exp_rd, input int hold);
    int          ready_at  = 0;
    int          extra     = 0;
    logic        wait_ok   = 1'b1;
    logic [31:0] rd_seen   = '0;
    logic        wr_seen   = 1'b0;
    @(negedge clk);
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    pcpi_valid = 1'b1;
    @(posedge clk);
    #1;
    pcpi_rs1  = $urandom;
    pcpi_rs2  = $urandom;
    pcpi_insn = $urandom;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (pcpi_wait !== (k < LAT)) wait_ok = 1'b0;
      if (pcpi_ready === 1'b1 && ready_at == 0) begin
        ready_at = k;
        rd_seen  = pcpi_rd;
        wr_seen  = pcpi_wr;
      end
    end
    check({tag, " latency"}, 64'(ready_at), 64'(LAT));
    check({tag, " rd"}, 64'(rd_seen), 64'(exp_rd));
    check({tag, " wr"}, 64'(wr_seen), 64'd1);
    check({tag, " wait profile"}, 64'(wait_ok), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wait || pcpi_rd != 0) extra++;
    end
    pcpi_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wait || pcpi_rd != 0) extra++;
    end
    check({tag, " quiet after ready"}, 64'(extra), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h023100B3, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB}; // MUL 7*-3
    vecs[1] = '{32'h023110B3, 32'h80000000, 32'h80000000, 32'h40000000}; // MULH
    vecs[2] = '{32'h023130B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}; // MULHU
    vecs[3] = '{32'h023120B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; // MULHSU
    vecs[4] = '{32'h023100B3, 32'h12345678, 32'h00000010, 32'h23456780}; // MUL
    vecs[5] = '{32'h023110B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}; // MULH -1*-1

    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(negedge clk);
    check("reset wait", 64'(pcpi_wait), 64'd0);
    check("reset ready", 64'(pcpi_ready), 64'd0);
    check("reset wr", 64'(pcpi_wr), 64'd0);
    check("reset rd", 64'(pcpi_rd), 64'd0);
    resetn = 1'b1;

    foreach (vecs[i]) run_mul($sformatf("vec%0d", i), vecs[i].insn, vecs[i].rs1,
                              vecs[i].rs2, vecs[i].exp_rd, 0);

    // Non-matching instructions: ADD and DIV (insn[14]=1) held for 20 cycles.
    for (int n = 0; n < 2; n++) begin
      logic bad = 1'b0;
      @(negedge clk);
      pcpi_insn  = (n == 0) ? 32'h003100B3 : 32'h023140B3;
      pcpi_rs1   = 32'd5;
      pcpi_rs2   = 32'd6;
      pcpi_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (pcpi_wait || pcpi_ready || pcpi_wr || pcpi_rd != 0) bad = 1'b1;
      end
      pcpi_valid = 1'b0;
      check($sformatf("nomatch%0d silent", n), 64'(bad), 64'd0);
    end
    run_mul("after nomatch", 32'h023100B3, 32'd9, 32'd9, 32'd81, 0);

    // Abort: drop valid 5 cycles into CALC.
    begin
      logic seen = 1'b0;
      @(negedge clk);
      pcpi_insn  = 32'h023100B3;
      pcpi_rs1   = 32'd3;
      pcpi_rs2   = 32'd4;
      pcpi_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("abort busy before drop", 64'(pcpi_wait), 64'd1);
      pcpi_valid = 1'b0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (pcpi_ready || pcpi_wr) seen = 1'b1;
      end
      check("abort no ready", 64'(seen), 64'd0);
      check("abort wait cleared", 64'(pcpi_wait), 64'd0);
    end
    run_mul("after abort", 32'h023100B3, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    pcpi_insn  = 32'h023130B3;
    pcpi_rs1   = 32'hDEADBEEF;
    pcpi_rs2   = 32'hCAFEF00D;
    pcpi_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async rst wait", 64'(pcpi_wait), 64'd0);
    check("async rst ready", 64'(pcpi_ready), 64'd0);
    check("async rst wr", 64'(pcpi_wr), 64'd0);
    check("async rst rd", 64'(pcpi_rd), 64'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_mul("after reset", 32'h023130B3, 32'hDEADBEEF, 32'hCAFEF00D,
            ref_mul(2'b11, 32'hDEADBEEF, 32'hCAFEF00D), 0);

    // Valid held 3 cycles past ready: exactly one pulse.
    run_mul("hold3", 32'h023120B3, 32'h80000001, 32'h7FFFFFFF, 32'hC0000000, 3);

    // Randomised requests against the arithmetic model.
    for (int t = 0; t < 24; t++) begin
      logic [1:0]  op = 2'($urandom_range(0, 3));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = $urandom;
      if (t % 6 == 0) a = 32'h80000000;
      if (t % 6 == 1) b = 32'hFFFFFFFF;
      run_mul($sformatf("rand%0d op%0d", t, op), mk_insn(op), a, b, ref_mul(op, a, b),
              int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
